// File: rtl/direct_mapped_cache_ctrl_if.sv
// rtl/direct_mapped_cache_ctrl_if.sv - CPU-side and memory-side bus of the direct-mapped cache controller
interface direct_mapped_cache_ctrl_if #(
  parameter int ADDR_WIDTH   = 15,
  parameter int OFFSET_WIDTH = 2,
  parameter int DATA_WIDTH   = 32
);
  logic                                  cpuReq;
  logic                                  cpuWrite;
  logic [ADDR_WIDTH-1:0]                 cpuAddress;
  logic [DATA_WIDTH-1:0]                 cpuWriteData;
  logic                                  cpuReady;
  logic [DATA_WIDTH-1:0]                 cpuReadData;
  logic                                  Hit;
  logic                                  Miss;
  logic                                  memReq;
  logic                                  memWrite;
  logic [ADDR_WIDTH-1:0]                 memAddress;
  logic [DATA_WIDTH-1:0]                 memWriteData;
  logic                                  memReady;
  logic [DATA_WIDTH*(2**OFFSET_WIDTH)-1:0] memReadData;
  logic [15:0]                           hitCount;
  logic [15:0]                           missCount;

  modport slave (
    input  cpuReq, cpuWrite, cpuAddress, cpuWriteData, memReady, memReadData,
    output cpuReady, cpuReadData, Hit, Miss, memReq, memWrite, memAddress,
           memWriteData, hitCount, missCount
  );

  modport master (
    output cpuReq, cpuWrite, cpuAddress, cpuWriteData, memReady, memReadData,
    input  cpuReady, cpuReadData, Hit, Miss, memReq, memWrite, memAddress,
           memWriteData, hitCount, missCount
  );
endinterface

// File: rtl/direct_mapped_cache_ctrl.sv
// rtl/direct_mapped_cache_ctrl.sv - blocking direct-mapped cache, write-through/no-write-allocate
module direct_mapped_cache_ctrl #(
  parameter int ADDR_WIDTH   = 15,
  parameter int INDEX_WIDTH  = 10,
  parameter int OFFSET_WIDTH = 2,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                          clock,
  input  logic                          reset_n,
  direct_mapped_cache_ctrl_if.slave     bus
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINES     = 2**INDEX_WIDTH;
  localparam int BLOCK_W   = DATA_WIDTH * (2**OFFSET_WIDTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COMPARE  = 3'd1;
  localparam logic [2:0] S_MEMREAD  = 3'd2;
  localparam logic [2:0] S_MEMWRITE = 3'd3;
  localparam logic [2:0] S_RESPOND  = 3'd4;

  logic [2:0]              r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_hit;
  logic [LINES-1:0]        r_valid;
  logic [TAG_WIDTH-1:0]    r_tag  [LINES];
  logic [BLOCK_W-1:0]      r_data [LINES];
  logic                    r_cpu_ready;
  logic                    r_hit_out;
  logic                    r_miss_out;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [15:0]             r_hit_cnt;
  logic [15:0]             r_miss_cnt;

  logic [TAG_WIDTH-1:0]    w_tag;
  logic [INDEX_WIDTH-1:0]  w_index;
  logic [OFFSET_WIDTH-1:0] w_offset;
  logic                    w_lookup_hit;
  logic [DATA_WIDTH-1:0]   w_word;

  assign w_tag        = r_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign w_index      = r_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_offset     = r_addr[OFFSET_WIDTH-1:0];
  assign w_lookup_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_word       = r_data[w_index][int'(w_offset)*DATA_WIDTH +: DATA_WIDTH];

  // Control state, valid bits and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_hit       <= 1'b0;
      r_valid     <= '0;
      r_cpu_ready <= 1'b0;
      r_hit_out   <= 1'b0;
      r_miss_out  <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      r_hit_out   <= 1'b0;
      r_miss_out  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cpuReq) begin
            r_addr  <= bus.cpuAddress;
            r_write <= bus.cpuWrite;
            r_wdata <= bus.cpuWriteData;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          r_hit       <= w_lookup_hit;
          r_mem_addr  <= r_write ? r_addr : {w_tag, w_index, {OFFSET_WIDTH{1'b0}}};
          r_mem_wdata <= r_wdata;
          if (r_write)           r_state <= S_MEMWRITE;
          else if (w_lookup_hit) r_state <= S_RESPOND;
          else                   r_state <= S_MEMREAD;
        end
        S_MEMREAD: begin
          if (bus.memReady) begin
            r_valid[w_index] <= 1'b1;
            r_state          <= S_RESPOND;
          end
        end
        S_MEMWRITE: begin
          if (bus.memReady) r_state <= S_RESPOND;
        end
        S_RESPOND: begin
          r_cpu_ready <= 1'b1;
          r_hit_out   <= r_hit;
          r_miss_out  <= !r_hit;
          r_rdata     <= r_write ? '0 : w_word;
          if (r_hit && r_hit_cnt != 16'hFFFF)   r_hit_cnt  <= r_hit_cnt + 16'd1;
          if (!r_hit && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clock) begin
    if (r_state == S_COMPARE && r_write && w_lookup_hit)
      r_data[w_index][int'(w_offset)*DATA_WIDTH +: DATA_WIDTH] <= r_wdata;
    else if (r_state == S_MEMREAD && bus.memReady) begin
      r_data[w_index] <= bus.memReadData;
      r_tag[w_index]  <= w_tag;
    end
  end

  assign bus.cpuReady     = r_cpu_ready;
  assign bus.cpuReadData  = r_rdata;
  assign bus.Hit          = r_hit_out;
  assign bus.Miss         = r_miss_out;
  assign bus.memReq       = (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign bus.memWrite     = (r_state == S_MEMWRITE);
  assign bus.memAddress   = r_mem_addr;
  assign bus.memWriteData = r_mem_wdata;
  assign bus.hitCount     = r_hit_cnt;
  assign bus.missCount    = r_miss_cnt;
endmodule

// File: tb/tb_direct_mapped_cache_ctrl.sv
// tb/tb_direct_mapped_cache_ctrl.sv - directed self-checking bench for direct_mapped_cache_ctrl
module tb_direct_mapped_cache_ctrl;
  logic clock;
  logic reset_n;

  direct_mapped_cache_ctrl_if #(.ADDR_WIDTH(15), .OFFSET_WIDTH(2), .DATA_WIDTH(32)) bus ();

  direct_mapped_cache_ctrl #(
    .ADDR_WIDTH(15), .INDEX_WIDTH(10), .OFFSET_WIDTH(2), .DATA_WIDTH(32)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]  res_rdata;
  logic         res_hit, res_miss, res_saw_mem, res_mem_wr, res_done;
  logic [14:0]  res_mem_addr;
  logic [31:0]  res_mem_wdata;
  int           res_lat, res_mem_lat;

  localparam logic [127:0] BLK1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] BLK2 = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
  localparam logic [127:0] BLK3 = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One CPU transaction; the bench plays memory, stalling memReady for 'stall' cycles.
  task automatic cpu_access(input logic wr, input logic [14:0] addr, input logic [31:0] wd,
                            input int stall, input logic [127:0] blk);
    int stalls = stall;
    int c      = 0;
    int c_r    = -100;
    @(negedge clock);
    bus.cpuReq       = 1'b1;
    bus.cpuWrite     = wr;
    bus.cpuAddress   = addr;
    bus.cpuWriteData = wd;
    @(posedge clock);
    #1;
    bus.cpuReq  = 1'b0;
    res_done    = 1'b0;
    res_saw_mem = 1'b0;
    for (int i = 0; i < 40 && !res_done; i++) begin
      @(negedge clock);
      c++;
      if (bus.cpuReady) begin
        res_rdata   = bus.cpuReadData;
        res_hit     = bus.Hit;
        res_miss    = bus.Miss;
        res_lat     = c - 1;
        res_mem_lat = c - c_r;
        res_done    = 1'b1;
        bus.memReady = 1'b0;
      end else if (bus.memReq) begin
        if (!res_saw_mem) begin
          res_saw_mem   = 1'b1;
          res_mem_addr  = bus.memAddress;
          res_mem_wr    = bus.memWrite;
          res_mem_wdata = bus.memWriteData;
        end else begin
          check("mem_addr_stable", {17'd0, bus.memAddress}, {17'd0, res_mem_addr});
          check("mem_wdata_stable", bus.memWriteData, res_mem_wdata);
          check("mem_write_stable", {31'd0, bus.memWrite}, {31'd0, res_mem_wr});
        end
        if (stalls > 0) begin
          stalls--;
          bus.memReady = 1'b0;
        end else begin
          bus.memReady    = 1'b1;
          bus.memReadData = blk;
          c_r = c;
        end
      end else begin
        bus.memReady = 1'b0;
      end
    end
    if (!res_done) check("cpu_ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.cpuReq       = 1'b0;
    bus.cpuWrite     = 1'b0;
    bus.cpuAddress   = '0;
    bus.cpuWriteData = '0;
    bus.memReady     = 1'b0;
    bus.memReadData  = '0;
    repeat (3) @(negedge clock);
    check("rst_cpuReady", {31'd0, bus.cpuReady}, 32'd0);
    check("rst_hit_miss", {30'd0, bus.Hit, bus.Miss}, 32'd0);
    check("rst_memReq", {30'd0, bus.memReq, bus.memWrite}, 32'd0);
    check("rst_cpuReadData", bus.cpuReadData, 32'd0);
    check("rst_memAddress", {17'd0, bus.memAddress}, 32'd0);
    check("rst_memWriteData", bus.memWriteData, 32'd0);
    check("rst_counts", {bus.hitCount, bus.missCount}, 32'd0);
    reset_n = 1'b1;

    // Cold read miss.
    cpu_access(1'b0, 15'h1005, 32'd0, 0, BLK1);
    check("cold_saw_mem", {31'd0, res_saw_mem}, 32'd1);
    check("cold_mem_addr", {17'd0, res_mem_addr}, 32'h1004);
    check("cold_mem_write", {31'd0, res_mem_wr}, 32'd0);
    check("cold_rdata", res_rdata, 32'h22222222);
    check("cold_hit_miss", {30'd0, res_hit, res_miss}, 32'd1);
    check("cold_mem_lat", res_mem_lat, 32'd2);
    check("cold_missCount", {16'd0, bus.missCount}, 32'd1);
    @(negedge clock);
    check("pulse_only_ready", {29'd0, bus.cpuReady, bus.Hit, bus.Miss}, 32'd0);

    // Read hit, same block.
    cpu_access(1'b0, 15'h1006, 32'd0, 0, BLK1);
    check("hit_saw_mem", {31'd0, res_saw_mem}, 32'd0);
    check("hit_latency", res_lat, 32'd2);
    check("hit_rdata", res_rdata, 32'h33333333);
    check("hit_hit_miss", {30'd0, res_hit, res_miss}, 32'd2);
    check("hit_hitCount", {16'd0, bus.hitCount}, 32'd1);

    // Conflict on index 1, then the original block refetched.
    cpu_access(1'b0, 15'h5004, 32'd0, 0, BLK2);
    check("conf_mem_addr", {17'd0, res_mem_addr}, 32'h5004);
    check("conf_rdata", res_rdata, 32'hA0A0A0A0);
    check("conf_miss", {30'd0, res_hit, res_miss}, 32'd1);
    cpu_access(1'b0, 15'h1004, 32'd0, 0, BLK1);
    check("refetch_saw_mem", {31'd0, res_saw_mem}, 32'd1);
    check("refetch_mem_addr", {17'd0, res_mem_addr}, 32'h1004);
    check("refetch_rdata", res_rdata, 32'h11111111);
    check("refetch_missCount", {16'd0, bus.missCount}, 32'd3);

    // Write hit with a 5-cycle memory stall.
    cpu_access(1'b1, 15'h1006, 32'hDEADBEEF, 5, BLK1);
    check("wh_mem_write", {31'd0, res_mem_wr}, 32'd1);
    check("wh_mem_addr", {17'd0, res_mem_addr}, 32'h1006);
    check("wh_mem_wdata", res_mem_wdata, 32'hDEADBEEF);
    check("wh_hit_miss", {30'd0, res_hit, res_miss}, 32'd2);
    check("wh_rdata_zero", res_rdata, 32'd0);
    check("wh_mem_lat", res_mem_lat, 32'd2);
    cpu_access(1'b0, 15'h1006, 32'd0, 0, BLK1);
    check("wh_read_saw_mem", {31'd0, res_saw_mem}, 32'd0);
    check("wh_read_rdata", res_rdata, 32'hDEADBEEF);
    check("wh_hitCount", {16'd0, bus.hitCount}, 32'd3);

    // Write miss: no allocation.
    cpu_access(1'b1, 15'h2000, 32'h12345678, 0, BLK3);
    check("wm_mem_write", {31'd0, res_mem_wr}, 32'd1);
    check("wm_mem_addr", {17'd0, res_mem_addr}, 32'h2000);
    check("wm_hit_miss", {30'd0, res_hit, res_miss}, 32'd1);
    cpu_access(1'b0, 15'h2000, 32'd0, 0, BLK3);
    check("wm_read_saw_mem", {31'd0, res_saw_mem}, 32'd1);
    check("wm_read_mem_write", {31'd0, res_mem_wr}, 32'd0);
    check("wm_read_rdata", res_rdata, 32'hC0C0C0C0);
    check("wm_missCount", {16'd0, bus.missCount}, 32'd5);

    // Reset during a refill.
    @(negedge clock);
    bus.cpuReq     = 1'b1;
    bus.cpuWrite   = 1'b0;
    bus.cpuAddress = 15'h1000;
    @(posedge clock);
    #1;
    bus.cpuReq = 1'b0;
    res_saw_mem = 1'b0;
    for (int i = 0; i < 10 && !res_saw_mem; i++) begin
      @(negedge clock);
      res_saw_mem = bus.memReq;
    end
    check("rr_refill_started", {31'd0, res_saw_mem}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rr_memReq_drop", {30'd0, bus.memReq, bus.cpuReady}, 32'd0);
    check("rr_counts", {bus.hitCount, bus.missCount}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cpu_access(1'b0, 15'h1006, 32'd0, 0, BLK1);
    check("rr_read_miss", {30'd0, res_hit, res_miss}, 32'd1);
    check("rr_read_mem_addr", {17'd0, res_mem_addr}, 32'h1004);
    check("rr_read_rdata", res_rdata, 32'h33333333);
    check("rr_missCount", {16'd0, bus.missCount}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
